// File: rtl/handshake_rx_sink_if.sv
// Bus between the Handshake receiver / downstream consumer and the rx sink.
// The sink takes the slave view; the environment driving it takes the master view.
interface handshake_rx_sink_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]       bdata;
  logic             bload;
  logic             bvalid;
  logic             breq;
  logic [7:0]       odata;
  logic             ovalid;
  logic             oready;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             chk_state;

  modport slave (
    input  bdata, bload, bvalid, oready,
    output breq, odata, ovalid, level, overflow, word_cnt, err_cnt, chk_state
  );

  modport master (
    output bdata, bload, bvalid, oready,
    input  breq, odata, ovalid, level, overflow, word_cnt, err_cnt, chk_state
  );
endinterface

// File: rtl/handshake_rx_sink.sv
// bclk-domain sink behind the Handshake receiver: FIFO capture, breq throttling,
// valid/ready re-presentation, and a byte-sequence gap checker with counters.
module handshake_rx_sink #(
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16,
  parameter int CHECK_EN = 1
) (
  input  logic bclk,
  input  logic brst,
  handshake_rx_sink_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] BREQ_LVL  = LW'(DEPTH - 2);

  typedef enum logic {CHK_IDLE = 1'b0, CHK_LOCK = 1'b1} chk_e;

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             breq_q, breq_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d, err_cnt_q, err_cnt_d;
  chk_e             chk_q, chk_d;
  logic [7:0]       exp_q, exp_d;
  logic             push_ok, pop, full, empty;
  logic             unused_bvalid;

  assign unused_bvalid = bus.bvalid;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign pop     = !empty && bus.oready;
  // Full still accepts when a pop frees the slot in the same cycle.
  assign push_ok = bus.bload && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push_ok);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    level_d    = level_q + LW'(push_ok) - LW'(pop);
    breq_d     = (level_d <= BREQ_LVL);
    overflow_d = overflow_q || (bus.bload && !push_ok);
    word_cnt_d = word_cnt_q;
    if (push_ok && word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;

    chk_d     = chk_q;
    exp_d     = exp_q;
    err_cnt_d = err_cnt_q;
    if (CHECK_EN != 0 && push_ok) begin
      exp_d = bus.bdata + 8'h01;
      if (chk_q == CHK_IDLE) begin
        chk_d = CHK_LOCK;
      end else if (bus.bdata != exp_q) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge bclk) begin
    if (brst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      breq_q     <= 1'b0;
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      chk_q      <= CHK_IDLE;
      exp_q      <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      breq_q     <= breq_d;
      overflow_q <= overflow_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      chk_q      <= chk_d;
      exp_q      <= exp_d;
    end
  end

  // Storage is not cleared by reset; the pointers alone define contents.
  always_ff @(posedge bclk) begin
    if (!brst && push_ok) mem_q[wr_ptr_q] <= bus.bdata;
  end

  assign bus.breq      = breq_q;
  assign bus.ovalid    = !empty;
  assign bus.odata     = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.chk_state = chk_q;
endmodule

// File: tb/tb_handshake_rx_sink.sv
// Directed bench for handshake_rx_sink with a scoreboard queue of expected words.
module tb_handshake_rx_sink;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic bclk = 1'b0;
  logic brst;
  always #5 bclk = ~bclk;

  handshake_rx_sink_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  handshake_rx_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W), .CHECK_EN(1)) dut (
    .bclk (bclk),
    .brst (brst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] sb [$];
  int         mlevel;
  bit         mbreq, movf, mlock;
  int         mwc, merr;
  logic [7:0] mexp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post_checks();
    chk("level", 32'(bus.level), 32'(mlevel));
    chk("breq", 32'(bus.breq), 32'(mbreq));
    chk("overflow", 32'(bus.overflow), 32'(movf));
    chk("word_cnt", 32'(bus.word_cnt), 32'(mwc));
    chk("err_cnt", 32'(bus.err_cnt), 32'(merr));
    chk("chk_state", 32'(bus.chk_state), 32'(mlock));
    chk("ovalid_post", 32'(bus.ovalid), 32'(mlevel != 0));
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) begin
      brst = 1'b1;
      bus.bload = i[0];
      bus.bdata = 8'hE0 + 8'(i);
      bus.oready = 1'b0;
      @(posedge bclk); #1;
      sb.delete();
      mlevel = 0; mbreq = 0; movf = 0; mlock = 0; mwc = 0; merr = 0; mexp = 8'h00;
      post_checks();
      chk("odata_rst", 32'(bus.odata), 32'h0);
      @(negedge bclk);
    end
    brst = 1'b0;
    bus.bload = 1'b0;
  endtask

  task automatic cyc(input bit ld, input logic [7:0] d, input bit rdy);
    bus.bload = ld; bus.bdata = d; bus.oready = rdy; bus.bvalid = ld;
    #1;
    chk("ovalid", 32'(bus.ovalid), 32'(mlevel != 0));
    if (mlevel == 0) begin
      chk("odata_empty", 32'(bus.odata), 32'h0);
    end else if (rdy) begin
      chk("odata", 32'(bus.odata), 32'(sb[0]));
      void'(sb.pop_front());
      mlevel--;
    end
    if (ld) begin
      if (mlevel < DEPTH) begin
        sb.push_back(d);
        mlevel++;
        if (mwc < (1 << CNT_W) - 1) mwc++;
        if (!mlock) mlock = 1;
        else if (d != mexp) merr++;
        mexp = d + 8'h01;
      end else begin
        movf = 1;
      end
    end
    mbreq = (mlevel <= DEPTH - 2);
    @(posedge bclk); #1;
    post_checks();
    @(negedge bclk);
    bus.bload = 1'b0;
  endtask

  initial begin
    brst = 1'b1;
    bus.bload = 1'b0; bus.bdata = 8'h00; bus.bvalid = 1'b0; bus.oready = 1'b0;
    @(negedge bclk);

    // 1. Reset with bload pulsing; breq rises on the second cycle after
    rst(3);
    chk("breq_first", 32'(bus.breq), 32'h0);
    cyc(0, 8'h00, 0);
    chk("breq_second", 32'(bus.breq), 32'h1);

    // 2. In-order stream with oready held high
    for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 1);
    cyc(0, 8'h00, 1);
    chk("t2_word_cnt", 32'(bus.word_cnt), 32'd8);
    chk("t2_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("t2_level", 32'(bus.level), 32'd0);

    // 3. Fill with oready low, then overflow on a 9th word
    for (int i = 0; i < 7; i++) cyc(1, 8'h18 + 8'(i), 0);
    chk("t3_breq_at7", 32'(bus.breq), 32'h0);
    cyc(1, 8'h1F, 0);
    chk("t3_level_full", 32'(bus.level), 32'd8);
    cyc(1, 8'h20, 0);
    chk("t3_overflow", 32'(bus.overflow), 32'h1);
    chk("t3_level_stays", 32'(bus.level), 32'd8);
    chk("t3_word_cnt", 32'(bus.word_cnt), 32'd16);

    // 4. Simultaneous push and pop while full; new word drains last
    cyc(1, 8'hA0, 1);
    chk("t4_level", 32'(bus.level), 32'd8);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1);
    chk("t4_empty", 32'(bus.level), 32'd0);
    chk("t4_overflow_sticky", 32'(bus.overflow), 32'h1);

    // 5. Sequence gap from a fresh checker
    rst(1);
    cyc(1, 8'hFE, 1);
    cyc(1, 8'hFF, 1);
    cyc(1, 8'h00, 1);
    chk("t5_wrap_ok", 32'(bus.err_cnt), 32'd0);
    cyc(1, 8'h05, 1);
    cyc(1, 8'h06, 1);
    cyc(0, 8'h00, 1);
    chk("t5_err_cnt", 32'(bus.err_cnt), 32'd1);

    // 6. Reset mid-operation, then re-lock on 0x42
    for (int i = 0; i < 5; i++) cyc(1, 8'h30 + 8'(i), 0);
    chk("t6_level5", 32'(bus.level), 32'd5);
    rst(1);
    chk("t6_ovalid", 32'(bus.ovalid), 32'h0);
    cyc(1, 8'h42, 0);
    chk("t6_lock", 32'(bus.chk_state), 32'h1);
    cyc(1, 8'h43, 0);
    cyc(1, 8'h50, 0);
    chk("t6_err_after_resync", 32'(bus.err_cnt), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
    chk("t6_drained", 32'(bus.level), 32'd0);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
